// File: rtl/ldc_pkg.sv
// Shared types and default sizing for the LDC front-end sequencer.
package ldc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam int unsigned LDC_W       = 16;
    localparam int unsigned LDC_DEPTH   = 4;
    localparam int unsigned LDC_TIMEOUT = 1023;

endpackage

// File: rtl/ldc_fifo.sv
// Synchronous first-word-fall-through FIFO holding (x, v) pairs for the sequencer.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ldc_fifo
    import ldc_pkg::*;
#(
    parameter int unsigned DW    = 2 * LDC_W,
    parameter int unsigned DEPTH = LDC_DEPTH
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;

    // Pointer update; a push and a pop in the same cycle leave occupancy unchanged.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);

endmodule

// File: rtl/ldc_sequencer.sv
// Front-end initiator for the LDC distance engine: buffers (x, v) pairs,
// issues one LDC job at a time, and returns each distance on a valid/ready stream.
module ldc_sequencer
    import ldc_pkg::*;
#(
    parameter int unsigned W       = LDC_W,
    parameter int unsigned DEPTH   = LDC_DEPTH,
    parameter int unsigned TIMEOUT = LDC_TIMEOUT
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_x_i,
    input  logic [W-1:0] in_v_i,
    output logic         ldc_start_o,
    output logic [W-1:0] ldc_x_o,
    output logic [W-1:0] ldc_v_o,
    input  logic         ldc_done_i,
    input  logic [W-1:0] ldc_distance_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_distance_o,
    output logic         out_timeout_o,
    output logic         busy_o
);

    localparam int unsigned   TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

    state_e        state_q;
    logic          ldc_start_q;
    logic [W-1:0]  ldc_x_q;
    logic [W-1:0]  ldc_v_q;
    logic          out_valid_q;
    logic [W-1:0]  out_distance_q;
    logic          out_timeout_q;
    logic          done_prev_q;
    logic [TW-1:0] tmo_cnt_q;

    logic [2*W-1:0] head_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic           push_s;
    logic           pop_s;
    logic           done_rise_s;
    logic [TW-1:0]  tmo_inc_s;

    ldc_fifo #(
        .DW    (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_s),
        .wdata_i ({in_x_i, in_v_i}),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Handshake decode, done edge detect, saturating timeout increment and pop decision.
    always_comb begin
        push_s      = in_valid_i & ~fifo_full_s;
        done_rise_s = ldc_done_i & ~done_prev_q;
        if (tmo_cnt_q == TMO_LIMIT) begin
            tmo_inc_s = tmo_cnt_q;
        end else begin
            tmo_inc_s = tmo_cnt_q + TW'(1);
        end
        pop_s = 1'b0;
        case (state_q)
            ST_IDLE: pop_s = ~fifo_empty_s;
            ST_HOLD: pop_s = out_ready_i & ~fifo_empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Job FSM with registered LDC operands, start pulse and result outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            ldc_start_q    <= 1'b0;
            ldc_x_q        <= {W{1'b0}};
            ldc_v_q        <= {W{1'b0}};
            out_valid_q    <= 1'b0;
            out_distance_q <= {W{1'b0}};
            out_timeout_q  <= 1'b0;
            done_prev_q    <= 1'b0;
            tmo_cnt_q      <= {TW{1'b0}};
        end else begin
            done_prev_q <= ldc_done_i;
            ldc_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        ldc_x_q     <= head_s[2*W-1:W];
                        ldc_v_q     <= head_s[W-1:0];
                        ldc_start_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tmo_cnt_q <= {TW{1'b0}};
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    tmo_cnt_q <= tmo_inc_s;
                    // A genuine completion beats a simultaneous timeout.
                    if (done_rise_s) begin
                        out_distance_q <= ldc_distance_i;
                        out_timeout_q  <= 1'b0;
                        out_valid_q    <= 1'b1;
                        state_q        <= ST_HOLD;
                    end else if (tmo_inc_s == TMO_LIMIT) begin
                        // WAIT has lasted TIMEOUT cycles with no completion.
                        out_distance_q <= {W{1'b0}};
                        out_timeout_q  <= 1'b1;
                        out_valid_q    <= 1'b1;
                        state_q        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        if (pop_s) begin
                            ldc_x_q     <= head_s[2*W-1:W];
                            ldc_v_q     <= head_s[W-1:0];
                            ldc_start_q <= 1'b1;
                            state_q     <= ST_ISSUE;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o     = ~fifo_full_s;
    assign ldc_start_o    = ldc_start_q;
    assign ldc_x_o        = ldc_x_q;
    assign ldc_v_o        = ldc_v_q;
    assign out_valid_o    = out_valid_q;
    assign out_distance_o = out_distance_q;
    assign out_timeout_o  = out_timeout_q;
    assign busy_o         = (state_q != ST_IDLE) | ~fifo_empty_s;

endmodule
